// File: rtl/mod_inverter.sv
`default_nettype none
// ============================================================================
// Module   : mod_inverter
// Brief    : Iterative binary extended-Euclid modular inverse, one step/cycle.
// Revision : 1.0
// ============================================================================
module mod_inverter #(
  parameter int WIDTH    = 255,
  parameter int MAX_ITER = 4 * WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                p,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                inv,
  output logic                            err,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter
);

  localparam int c_IW = $clog2(MAX_ITER + 1);
  localparam int c_XW = WIDTH + 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [c_IW-1:0] c_MAX_CNT = c_IW'(MAX_ITER);
  localparam logic [c_XW-1:0] c_ONE     = c_XW'(1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_XW-1:0] r_u, r_v, r_x1, r_x2, r_p;
  logic [c_XW-1:0] w_u_nxt, w_v_nxt, w_x1_nxt, w_x2_nxt;
  logic [c_IW-1:0] r_cnt;
  logic [WIDTH-1:0] r_inv;
  logic            r_err;
  logic [c_IW-1:0] r_iter;

  logic w_accept, w_bad, w_u_one, w_v_one, w_gcd_err, w_cap, w_term;

  // x/2 mod m; the extra top bit keeps x+m from overflowing.
  function automatic logic [c_XW-1:0] half_mod(input logic [c_XW-1:0] x,
                                                input logic [c_XW-1:0] m);
    logic [c_XW-1:0] s;
    s = x[0] ? (x + m) : x;
    return s >> 1;
  endfunction

  function automatic logic [c_XW-1:0] sub_mod(input logic [c_XW-1:0] x,
                                               input logic [c_XW-1:0] y,
                                               input logic [c_XW-1:0] m);
    return (x >= y) ? (x - y) : (x + m - y);
  endfunction

  assign w_accept  = in_valid && (r_state == c_IDLE);
  assign w_bad     = (a == '0) || !p[0] || (p < WIDTH'(3)) || (a >= p);
  assign w_u_one   = (r_u == c_ONE);
  assign w_v_one   = (r_v == c_ONE);
  assign w_gcd_err = (r_u == '0) || (r_v == '0);
  assign w_cap     = (r_cnt == c_MAX_CNT);
  assign w_term    = w_u_one || w_v_one || w_gcd_err || w_cap;

  always_comb begin
    w_u_nxt  = r_u;
    w_v_nxt  = r_v;
    w_x1_nxt = r_x1;
    w_x2_nxt = r_x2;
    if (!r_u[0]) begin
      w_u_nxt  = r_u >> 1;
      w_x1_nxt = half_mod(r_x1, r_p);
    end else if (!r_v[0]) begin
      w_v_nxt  = r_v >> 1;
      w_x2_nxt = half_mod(r_x2, r_p);
    end else if (r_u >= r_v) begin
      w_u_nxt  = r_u - r_v;
      w_x1_nxt = sub_mod(r_x1, r_x2, r_p);
    end else begin
      w_v_nxt  = r_v - r_u;
      w_x2_nxt = sub_mod(r_x2, r_x1, r_p);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = w_bad ? c_DONE : c_RUN;
      c_RUN:   if (w_term) w_state_nxt = c_DONE;
      c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_IDLE);
    out_valid = (r_state == c_DONE);
  end

  assign inv  = r_inv;
  assign err  = r_err;
  assign iter = r_iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_u    <= '0;
      r_v    <= '0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_inv  <= '0;
      r_err  <= 1'b0;
      r_iter <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_bad) begin
              r_inv  <= '0;
              r_err  <= 1'b1;
              r_iter <= '0;
            end else begin
              r_u  <= {1'b0, a};
              r_v  <= {1'b0, p};
              r_p  <= {1'b0, p};
              r_x1 <= c_ONE;
              r_x2 <= '0;
            end
          end
        end
        c_RUN: begin
          if (w_term) begin
            r_iter <= r_cnt;
            if (w_u_one) begin
              r_inv <= r_x1[WIDTH-1:0];
              r_err <= 1'b0;
            end else if (w_v_one) begin
              r_inv <= r_x2[WIDTH-1:0];
              r_err <= 1'b0;
            end else begin
              r_inv <= '0;
              r_err <= 1'b1;
            end
          end else begin
            r_u   <= w_u_nxt;
            r_v   <= w_v_nxt;
            r_x1  <= w_x1_nxt;
            r_x2  <= w_x2_nxt;
            r_cnt <= r_cnt + c_IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mod_inverter.md
MOD_INVERTER -- requirements
Module: mod_inverter

Interface
REQ-001 SHALL have parameter WIDTH, default 255, meaning the operand, modulus and result width in bits.
REQ-002 SHALL have parameter MAX_ITER, default 4*WIDTH, meaning the iteration cap before forced error.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts an operand pair this cycle.
REQ-007 SHALL have port a, input, WIDTH bits, meaning the value to invert.
REQ-008 SHALL have port p, input, WIDTH bits, meaning the runtime modulus.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning a result is held.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 SHALL have port inv, output, WIDTH bits, meaning a^-1 mod p, or 0 when err is high.
REQ-012 SHALL have port err, output, 1 bit, meaning no inverse was produced.
REQ-013 SHALL have port iter, output, clog2(MAX_ITER+1) bits, meaning the number of steps used.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 SHALL accept on in_valid&&in_ready, latching a and p, clearing the step counter, and entering RUN on the next edge; in_valid outside IDLE is ignored.
REQ-016 SHALL go directly from IDLE to DONE with err=1, inv=0 and iter=0 when the accepted a==0, p[0]==0, p<3 or a>=p.
REQ-017 SHALL otherwise initialise u=a, v=p, x1=1, x2=0; u, v, x1 and x2 are held at WIDTH+1 bits so x+p never overflows.
REQ-018 SHALL evaluate termination in RUN before stepping, in priority order: u==1 gives inv=x1; else v==1 gives inv=x2; else u==0 or v==0 gives err (gcd≠1); else counter==MAX_ITER gives err. Any termination moves to DONE on that edge.
REQ-019 SHALL otherwise perform exactly one step per cycle and increment the counter, in priority order:
 - u even: u>>=1; x1 = x1 even ? x1>>1 : (x1+p)>>1.
 - else v even: the same update on v and x2.
 - else u>=v: u-=v; x1 = x1>=x2 ? x1-x2 : x1+p-x2.
 - else: v-=u; x2 = x2>=x1 ? x2-x1 : x2+p-x1.
REQ-020 SHALL keep all x values in [0,p-1] at every step; inv SHALL always be < p.
REQ-021 SHALL make latency from the accept edge to out_valid=1 equal to iter+2 cycles on the normal path and 1 cycle on the REQ-016 path.
REQ-022 SHALL hold inv, err and iter stable in DONE until out_valid&&out_ready; the next edge returns to IDLE with out_valid=0 and in_ready=1, giving one idle cycle between results.
REQ-023 SHALL have no combinational path from in_valid or out_ready to in_ready or out_valid.
REQ-024 SHALL make a result depend only on the latched operands; changes on a or p after accept have no effect.

Reset
REQ-025 SHALL on rst=1 at a clock edge enter IDLE with in_ready=1, out_valid=0, err=0, inv=0, iter=0, and all internal registers at 0.
REQ-026 SHALL make rst during RUN or DONE discard the operation with no out_valid pulse; the first post-reset accept is honoured normally.

Verification
REQ-027 SHALL pass WIDTH=8: p=251, a=3 -> out_valid with inv=84, err=0, iter<=32.
REQ-028 SHALL pass WIDTH=8: p=251, a=1 -> inv=1, err=0, iter=0, out_valid two cycles after accept.
REQ-029 SHALL pass WIDTH=8: p=15, a=6 -> err=1, inv=0 via the gcd path; and p=251, a=0 -> err=1, iter=0, out_valid one cycle after accept.
REQ-030 SHALL pass default WIDTH: p=2^255-19, a=2 -> inv=2^254-9, err=0.
REQ-031 SHALL pass backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE the next cycle, and back-to-back operands are both processed correctly.
REQ-032 SHALL pass reset mid-RUN: rst for 1 cycle -> IDLE, no out_valid; a random sweep of a against a software model passes with zero mismatches.
